keccak_pad_absorber: RTL and testbench

- Streaming pad10*1 padder for the KMAC/SHA-3 datapath.
- Accepts a message one byte per cycle and assembles rate-sized blocks.
- Applies the domain-separation suffix byte and the final 0x80 bit at byte granularity.
- Hands each block to the Keccak permutation stage over a valid/ready handshake. Replaces the scalar z-search padder with a real-time, rate-configurable absorber.

---
 rtl/kmac_pkg.sv | 12 +
 rtl/pad_block_buf.sv | 30 +++
 rtl/keccak_pad_absorber.sv | 130 +++++++++++++
 tb/tb_keccak_pad_absorber.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/kmac_pkg.sv
// kmac_pkg: shared FSM state, rate and domain-separation constants for the KMAC/SHA-3 datapath
package kmac_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD, S_EMIT} state_e;
  localparam int RATE_SHAKE128 = 168;
  localparam int RATE_SHA3_256 = 136;
  localparam int RATE_SHA3_384 = 104;
  localparam int RATE_SHA3_512 = 72;
  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] DS_SHAKE  = 8'h1F;
  localparam logic [7:0] DS_CSHAKE = 8'h04;
  localparam logic [7:0] PAD_FINAL = 8'h80;
endpackage

// File: rtl/pad_block_buf.sv
// pad_block_buf: byte register file with one byte write, two XOR-in ports and synchronous clear
module pad_block_buf #(
  parameter int NB = 168,
  parameter int IW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [7:0]      wdata,
  input  logic            xa_en,
  input  logic [IW-1:0]   xa_addr,
  input  logic [7:0]      xa_data,
  input  logic            xb_en,
  input  logic [IW-1:0]   xb_addr,
  input  logic [7:0]      xb_data,
  output logic [8*NB-1:0] data
);
  for (genvar i = 0; i < NB; i++) begin : g_byte
    logic [7:0] q;
    // both XOR ports may target the same byte; their contributions combine
    always_ff @(posedge clk)
      if (!rst_n || clr) q <= '0;
      else q <= ((we && waddr == IW'(i)) ? wdata : q)
              ^ ((xa_en && xa_addr == IW'(i)) ? xa_data : 8'h00)
              ^ ((xb_en && xb_addr == IW'(i)) ? xb_data : 8'h00);
    assign data[8*i +: 8] = q;
  end
endmodule

// File: rtl/keccak_pad_absorber.sv
// keccak_pad_absorber: byte-streaming pad10*1 padder assembling rate-sized blocks for the Keccak stage
module keccak_pad_absorber
  import kmac_pkg::*;
#(
  parameter int RATE_MAX_BYTES = 168,
  parameter int RIDX_W         = 8,
  parameter int BCNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [RIDX_W-1:0]         rate_bytes,
  input  logic [7:0]                dsbyte,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_keep,
  input  logic                      in_last,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [8*RATE_MAX_BYTES-1:0] blk_data,
  output logic                      blk_last,
  output logic                      done,
  output logic [BCNT_W-1:0]         blk_count,
  output logic                      err
);
  state_e state, state_d;
  logic [RIDX_W-1:0] idx, idx_d, rate, rate_d, nidx;
  logic [7:0] ds, ds_d;
  logic last_q, last_d, pend, pend_d, done_d, err_d;
  logic [BCNT_W-1:0] cnt, cnt_d;
  logic clr, we, xor_en, rate_ok;
  assign in_ready  = state == S_FILL;
  assign blk_valid = state == S_EMIT;
  assign blk_last  = last_q;
  assign blk_count = cnt;
  assign nidx      = idx + RIDX_W'(in_keep);
  assign rate_ok   = rate_bytes >= RIDX_W'(2) && rate_bytes <= RIDX_W'(RATE_MAX_BYTES);
  always_comb begin
    state_d = state;
    idx_d   = idx;
    rate_d  = rate;
    ds_d    = ds;
    last_d  = last_q;
    pend_d  = pend;
    cnt_d   = cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    we      = 1'b0;
    xor_en  = 1'b0;
    case (state)
      S_IDLE:
        if (start && rate_ok) begin
          rate_d  = rate_bytes;
          ds_d    = dsbyte;
          clr     = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = S_FILL;
        end else if (start) err_d = 1'b1;
      S_FILL:
        if (in_valid) begin
          we    = in_keep;
          idx_d = nidx;
          // a message ending exactly on the boundary still needs a separate padding block
          if (nidx == rate) begin
            state_d = S_EMIT;
            last_d  = 1'b0;
            pend_d  = in_last;
          end else if (in_last) state_d = S_PAD;
        end
      S_PAD: begin
        xor_en  = 1'b1;
        last_d  = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT:
        if (blk_ready) begin
          cnt_d  = &cnt ? cnt : cnt + 1'b1;
          clr    = 1'b1;
          idx_d  = '0;
          last_d = 1'b0;
          pend_d = 1'b0;
          done_d = last_q;
          state_d = last_q ? S_IDLE : pend ? S_PAD : S_FILL;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      rate   <= '0;
      ds     <= '0;
      last_q <= 1'b0;
      pend   <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      rate   <= rate_d;
      ds     <= ds_d;
      last_q <= last_d;
      pend   <= pend_d;
      cnt    <= cnt_d;
      done   <= done_d;
      err    <= err_d;
    end
  pad_block_buf #(.NB(RATE_MAX_BYTES), .IW(RIDX_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .we      (we),
    .waddr   (idx),
    .wdata   (in_data),
    .xa_en   (xor_en),
    .xa_addr (idx),
    .xa_data (ds),
    .xb_en   (xor_en),
    .xb_addr (rate - RIDX_W'(1)),
    .xb_data (PAD_FINAL),
    .data    (blk_data)
  );
endmodule

// File: tb/tb_keccak_pad_absorber.sv
// tb_keccak_pad_absorber: table-driven pad10*1 vectors plus backpressure, reset and error sequences
module tb_keccak_pad_absorber;
  localparam int RB = 168;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_keep = 0, in_last = 0, blk_ready = 1;
  logic [7:0] rate_bytes = 0, dsbyte = 0, in_data = 0;
  logic in_ready, blk_valid, blk_last, done, err;
  logic [8*RB-1:0] blk_data;
  logic [15:0] blk_count;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  keccak_pad_absorber dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rate_bytes(rate_bytes), .dsbyte(dsbyte),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .done(done), .blk_count(blk_count), .err(err)
  );
  typedef struct {
    int rate; logic [7:0] ds; int len; logic [7:0] seed; int nblk;
    int i0; logic [7:0] v0; int i1; logic [7:0] v1;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_blk(input string nm, input logic [8*RB-1:0] exp);
    n_cmp++;
    if (blk_data !== exp) begin
      n_fail++;
      for (int j = 0; j < RB; j++)
        if (blk_data[8*j +: 8] !== exp[8*j +: 8]) begin
          $display("FAIL %s: byte %0d got %0h expected %0h", nm, j, blk_data[8*j +: 8], exp[8*j +: 8]);
          break;
        end
    end
  endtask
  task automatic do_start(input int r, input logic [7:0] d);
    start = 1; rate_bytes = 8'(r); dsbyte = d;
    @(negedge clk);
    start = 0; rate_bytes = 8'h00; dsbyte = 8'hFF;
  endtask
  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic wait_sig(input string nm, input int which);
    int cyc = 0;
    while ((which == 0 ? blk_valid : done) !== 1'b1 && cyc < 400) begin
      @(negedge clk); cyc++;
    end
    chk(nm, cyc < 400, 1);
  endtask
  task automatic run_msg(input int rate, input logic [7:0] ds, input int len, input logic [7:0] seed,
                         input int nblk, output logic [8*RB-1:0] last_blk);
    logic [7:0] m [0:1023];
    logic [8*RB-1:0] ev;
    int beats, pos, b, cyc;
    logic got_done;
    for (int k = 0; k < 1024; k++) m[k] = k < len ? 8'(int'(seed) + k) : 8'h00;
    m[len] ^= ds;
    m[nblk*rate-1] ^= 8'h80;
    blk_ready = 1;
    do_start(rate, ds);
    beats = len == 0 ? 1 : len;
    pos = 0; b = 0; cyc = 0; got_done = 0; last_blk = '0;
    while (!got_done && cyc < 4000) begin
      if (blk_valid) begin
        if (b < nblk) begin
          ev = '0;
          for (int j = 0; j < rate; j++) ev[8*j +: 8] = m[b*rate+j];
          chk_blk($sformatf("block r%0d l%0d b%0d", rate, len, b), ev);
          chk("blk_last", blk_last, b == nblk - 1);
        end else chk("extra block", b, nblk - 1);
        last_blk = blk_data;
        b++;
      end
      if (done) got_done = 1;
      in_valid = pos < beats;
      in_data  = 8'(int'(seed) + pos);
      in_keep  = len != 0;
      in_last  = pos == beats - 1;
      if (in_valid && in_ready) pos++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 0; in_last = 0;
    chk("done seen", got_done, 1);
    chk("block count", b, nblk);
    chk("blk_count", blk_count, 16'(nblk));
    chk("done one cycle", done, 0);
  endtask
  initial begin
    logic [8*RB-1:0] lb, cap;
    vecs[0] = '{136, 8'h06,   0, 8'h00, 1,   0, 8'h06, 135, 8'h80};
    vecs[1] = '{136, 8'h06, 135, 8'h00, 1, 134, 8'h86, 135, 8'h86};
    vecs[2] = '{136, 8'h06, 136, 8'h10, 2,   0, 8'h06, 135, 8'h80};
    vecs[3] = '{168, 8'h1F,   3, 8'h61, 1,   3, 8'h1F, 167, 8'h80};
    vecs[4] = '{ 72, 8'h04, 150, 8'h20, 3,   6, 8'h04,  71, 8'h80};
    vecs[5] = '{104, 8'h06, 103, 8'h05, 1, 102, 8'h6B, 103, 8'h86};
    vecs[6] = '{  2, 8'h1F,   1, 8'h61, 1,   0, 8'h61,   1, 8'h9F};
    @(negedge clk);
    do_reset();
    chk("rst in_ready", in_ready, 0);
    chk("rst blk_valid", blk_valid, 0);
    chk("rst blk_data zero", blk_data == '0, 1);
    chk("rst flags", {blk_last, done, err}, 0);
    chk("rst blk_count", blk_count, 0);
    for (int v = 0; v < 7; v++) begin
      run_msg(vecs[v].rate, vecs[v].ds, vecs[v].len, vecs[v].seed, vecs[v].nblk, lb);
      chk($sformatf("vec%0d byte%0d", v, vecs[v].i0), lb[8*vecs[v].i0 +: 8], vecs[v].v0);
      chk($sformatf("vec%0d byte%0d", v, vecs[v].i1), lb[8*vecs[v].i1 +: 8], vecs[v].v1);
    end
    // backpressure on a full non-final block, with a stray start that must be ignored
    blk_ready = 0;
    do_start(72, 8'h06);
    for (int k = 0; k < 72; k++) begin
      in_valid = 1; in_data = 8'(k); in_keep = 1; in_last = 0;
      @(negedge clk);
    end
    in_valid = 0;
    start = 1; rate_bytes = 8'd1;
    cap = blk_data;
    chk("bp first byte", cap[7:0], 8'h00);
    chk("bp byte71", cap[8*71 +: 8], 8'h47);
    for (int c = 0; c < 5; c++) begin
      chk("bp blk_valid", blk_valid, 1);
      chk("bp data stable", blk_data == cap, 1);
      chk("bp blk_last", blk_last, 0);
      chk("bp in_ready", in_ready, 0);
      if (c < 4) @(negedge clk);
      chk("bp err", err, 0);
    end
    start = 0; rate_bytes = 0;
    blk_ready = 1;
    @(negedge clk);
    chk("bp in_ready after", in_ready, 1);
    chk("bp blk_valid after", blk_valid, 0);
    chk("bp blk_count", blk_count, 1);
    in_valid = 1; in_data = 8'hAA; in_keep = 1; in_last = 1;
    @(negedge clk);
    in_valid = 0; in_last = 0;
    wait_sig("bp final wait", 0);
    chk("bp final byte0", blk_data[7:0], 8'hAA);
    chk("bp final byte1", blk_data[15:8], 8'h06);
    chk("bp final byte71", blk_data[8*71 +: 8], 8'h80);
    chk("bp final last", blk_last, 1);
    wait_sig("bp done wait", 1);
    chk("bp count2", blk_count, 2);
    // reset in the middle of a message
    do_start(136, 8'h06);
    for (int k = 0; k < 40; k++) begin
      in_valid = 1; in_data = 8'hC0 + 8'(k); in_keep = 1; in_last = 0;
      @(negedge clk);
    end
    in_valid = 0;
    do_reset();
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst blk_data", blk_data == '0, 1);
    chk("mid rst flags", {blk_valid, blk_last, done, err}, 0);
    chk("mid rst blk_count", blk_count, 0);
    run_msg(136, 8'h06, 3, 8'h61, 1, lb);
    chk("post rst byte3", lb[31:24], 8'h06);
    chk("post rst byte39", lb[8*39 +: 8], 8'h00);
    // out-of-range rates are rejected
    start = 1; rate_bytes = 8'd1; dsbyte = 8'h06;
    @(negedge clk);
    start = 0;
    chk("err rate1", err, 1);
    chk("err in_ready", in_ready, 0);
    @(negedge clk);
    chk("err pulse end", err, 0);
    chk("err idle", in_ready, 0);
    start = 1; rate_bytes = 8'd169;
    @(negedge clk);
    start = 0;
    chk("err rate169", err, 1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
